pipe_hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage MIPS core, sitting beside the Decoder and the stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Produces PC/IF-ID write enables and stage flushes for load-use hazards and taken branches.
- Runs the data-memory request/acknowledge handshake for lw/sw in MEM, freezing the whole pipeline on wait states and flagging memory timeouts.
- Keeps saturating stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core.
// Generates PC / IF-ID enables and stage flushes for load-use hazards and
// taken branches, runs the data-memory req/ack handshake for lw/sw in MEM
// (freezing the pipe on wait states, trapping on timeout), and keeps
// saturating stall / flush performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             ex_branch_taken_i,
  input  logic             exmem_memread_i,
  input  logic             exmem_memwrt_i,
  input  logic             dmem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             pipe_hold_o,
  output logic             dmem_req_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // Memory handshake FSM encoding.
  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StMemWait = 2'd1;
  localparam logic [1:0] StErr     = 2'd2;

  localparam logic [WAIT_W-1:0] MaxWaitCnt = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CntMax     = '1;

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic mem_op;
  logic mem_hold;
  logic mem_req;
  logic load_use;
  logic lu_stall;
  logic br_flush;

  assign mem_op = exmem_memread_i | exmem_memwrt_i;

  // Load in EX whose destination is read by the instruction in ID; $0 never
  // creates a dependency.
  assign load_use = idex_memread_i && (idex_rt_i != 5'd0) &&
                    ((idex_rt_i == ifid_rs_i) ||
                     (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

  // Memory handshake: next state, wait counter, request and hold.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_hold   = 1'b0;
    mem_req    = 1'b0;
    unique case (state_q)
      StRun: begin
        mem_req = mem_op;
        // An ack in the same cycle is a zero-wait access and never stalls.
        if (mem_op && !dmem_ack_i) begin
          mem_hold   = 1'b1;
          state_d    = StMemWait;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      StMemWait: begin
        mem_req  = 1'b1;
        mem_hold = ~dmem_ack_i;
        if (dmem_ack_i) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == MaxWaitCnt) begin
          state_d = StErr;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      StErr: begin
        // Pipeline stays frozen with the request dropped until reset.
        mem_hold = 1'b1;
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Pipeline control outputs by priority: reset, memory hold, branch, load-use.
  always_comb begin
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    pipe_hold_o  = 1'b0;
    lu_stall     = 1'b0;
    br_flush     = 1'b0;
    if (rst_i) begin
      // Everything quiet while in reset.
    end else if (mem_hold) begin
      // Pending branch / hazard is re-evaluated once the hold clears.
      pipe_hold_o = 1'b1;
    end else if (ex_branch_taken_i) begin
      // The ID instruction is discarded, so a load-use on it is irrelevant.
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      br_flush     = 1'b1;
    end else if (load_use) begin
      // One bubble: load_use drops as soon as the lw leaves EX.
      idex_flush_o = 1'b1;
      lu_stall     = 1'b1;
    end else begin
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
    end
  end

  assign dmem_req_o = mem_req & ~rst_i;

  // Sticky error and saturating performance counters.
  always_comb begin
    mem_err_d   = mem_err_q | (state_d == StErr);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((pipe_hold_o || lu_stall) && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (br_flush && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err_o   = mem_err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (built with CNT_W=4 so counter
// saturation is reachable quickly).
module tb_pipe_hazard_ctrl;

  localparam int unsigned CntW = 4;

  // Expected vector bit order: {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, dmem_req}
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       ex_mr;
    logic [4:0] ex_rt;
    logic       br;
    logic       mr;
    logic       mw;
    logic       ack;
    logic [5:0] exp;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      ifid_rs, ifid_rt, idex_rt;
  logic            ifid_uses_rt, idex_memread, ex_branch_taken;
  logic            exmem_memread, exmem_memwrt, dmem_ack;
  logic            pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, dmem_req;
  logic            mem_err;
  logic [CntW-1:0] stall_cnt, flush_cnt;
  logic [5:0]      act;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] exp_q[$];
  string      name_q[$];

  pipe_hazard_ctrl #(
    .MAX_WAIT(15),
    .WAIT_W  (4),
    .CNT_W   (CntW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ifid_rs_i        (ifid_rs),
    .ifid_rt_i        (ifid_rt),
    .ifid_uses_rt_i   (ifid_uses_rt),
    .idex_memread_i   (idex_memread),
    .idex_rt_i        (idex_rt),
    .ex_branch_taken_i(ex_branch_taken),
    .exmem_memread_i  (exmem_memread),
    .exmem_memwrt_i   (exmem_memwrt),
    .dmem_ack_i       (dmem_ack),
    .pc_write_o       (pc_write),
    .ifid_write_o     (ifid_write),
    .ifid_flush_o     (ifid_flush),
    .idex_flush_o     (idex_flush),
    .pipe_hold_o      (pipe_hold),
    .dmem_req_o       (dmem_req),
    .mem_err_o        (mem_err),
    .stall_cnt_o      (stall_cnt),
    .flush_cnt_o      (flush_cnt)
  );

  always #5 clk = ~clk;

  assign act = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, dmem_req};

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                              input logic ex_mr, input logic [4:0] ex_rt, input logic br,
                              input logic mr, input logic mw, input logic ack,
                              input logic [5:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.ex_mr = ex_mr; v.ex_rt = ex_rt;
    v.br = br; v.mr = mr; v.mw = mw; v.ack = ack; v.exp = exp;
    return v;
  endfunction

  // Drive one cycle, push expectation, compare combinational outputs at negedge.
  task automatic step(input vec_t v, input string name);
    logic [5:0] e;
    string      n;
    ifid_rs = v.rs; ifid_rt = v.rt; ifid_uses_rt = v.uses_rt;
    idex_memread = v.ex_mr; idex_rt = v.ex_rt; ex_branch_taken = v.br;
    exmem_memread = v.mr; exmem_memwrt = v.mw; dmem_ack = v.ack;
    exp_q.push_back(v.exp);
    name_q.push_back(name);
    @(negedge clk);
    e = exp_q.pop_front();
    n = name_q.pop_front();
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: outputs pc/ifw/iff/idf/hold/req = %b, required %b", n, act, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000), name);
    rst = 1'b0;
  endtask

  vec_t tbl[10];
  vec_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b110000);
    //           rs rt use exmr exrt br mr mw ack  expected
    tbl[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b110000);  // idle
    tbl[1] = mk(2, 7, 0, 1, 2, 0, 0, 0, 0, 6'b000100);  // lu on rs
    tbl[2] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 6'b110000);  // $0 never hazards
    tbl[3] = mk(3, 2, 0, 1, 2, 0, 0, 0, 0, 6'b110000);  // rt match, rt unused
    tbl[4] = mk(3, 2, 1, 1, 2, 0, 0, 0, 0, 6'b000100);  // lu on rt
    tbl[5] = mk(2, 7, 0, 1, 2, 1, 0, 0, 0, 6'b111100);  // branch beats lu
    tbl[6] = mk(4, 5, 1, 0, 0, 1, 0, 0, 0, 6'b111100);  // branch alone
    tbl[7] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 6'b110001);  // zero-wait lw
    tbl[8] = mk(6, 0, 0, 1, 6, 0, 0, 1, 1, 6'b000101);  // zero-wait sw + lu
    tbl[9] = mk(5, 9, 1, 1, 2, 0, 0, 0, 0, 6'b110000);  // lw in EX, no match

    rst = 1'b1;
    #1;
    do_reset("reset_outputs");
    chk("reset_stall_cnt", int'(stall_cnt), 0);
    chk("reset_flush_cnt", int'(flush_cnt), 0);
    chk("reset_mem_err", int'(mem_err), 0);

    // Table sweep
    for (int i = 0; i < 10; i++) step(tbl[i], $sformatf("table[%0d]", i));
    chk("table_stall_cnt", int'(stall_cnt), 3);
    chk("table_flush_cnt", int'(flush_cnt), 2);

    // Single load-use bubble, then normal flow
    do_reset("reset_lu");
    step(tbl[1], "lu_bubble");
    step(mk(2, 7, 0, 0, 0, 0, 0, 0, 0, 6'b110000), "lu_after");
    chk("lu_stall_cnt", int'(stall_cnt), 1);

    // Branch together with load-use
    do_reset("reset_br");
    step(tbl[5], "br_lu");
    chk("br_flush_cnt", int'(flush_cnt), 1);
    chk("br_stall_cnt", int'(stall_cnt), 0);

    // sw with ack on the fourth request cycle
    do_reset("reset_sw");
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000011), $sformatf("sw_wait%0d", i));
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b110001), "sw_ack");
    step(idle, "sw_after");
    chk("sw_stall_cnt", int'(stall_cnt), 3);
    chk("sw_mem_err", int'(mem_err), 0);

    // Timeout into ERR, then reset out of it
    do_reset("reset_err");
    for (int i = 0; i < 16; i++) step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000011), $sformatf("to_wait%0d", i));
    step(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 6'b000010), "err_first");
    chk("err_mem_err", int'(mem_err), 1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000010), "err_sticky");
    chk("err_mem_err_sticky", int'(mem_err), 1);
    chk("err_flush_cnt", int'(flush_cnt), 0);
    rst = 1'b1;
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000000), "err_reset_drop_req");
    rst = 1'b0;
    chk("post_reset_mem_err", int'(mem_err), 0);
    chk("post_reset_stall", int'(stall_cnt), 0);
    chk("post_reset_flush", int'(flush_cnt), 0);
    step(idle, "post_reset_run");

    // Stall counter saturation under a continuous hold
    do_reset("reset_sat");
    for (int i = 0; i < 14; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000011), $sformatf("sat_a%0d", i));
    chk("sat_cnt_14", int'(stall_cnt), 14);
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000011), "sat_a14");
    chk("sat_cnt_15", int'(stall_cnt), 15);
    for (int i = 0; i < 4; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, (i < 1) ? 6'b000011 : 6'b000010), $sformatf("sat_b%0d", i));
    chk("sat_cnt_hold", int'(stall_cnt), 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
